// File: rtl/cos_dp.sv
// ---------------------------------------------------------------------------
// cos_dp -- datapath for an iterative cos(x) evaluator (Q2.14 fixed point)
//
// Evaluates the Taylor series
//   C = 1 - x^2/2! + x^4/4! - ... + x^16/16!
// in Horner-free "running term" form. Each new term is the previous term
// scaled by -x^2 / ((2k+1)(2k+2)):
//   T <- T * X      (selXR=1, ldT=1)
//   T <- T * R(K)   (selXR=0, ldT=1)
//   C <- C + T, K++ (ldC=1, cntUp=1)
// The sequencing is done by an external controller. One shared signed
// multiplier serves the x^2 load and both per-iteration products.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   x_in    : operand x, signed Q2.14, used only when ldX=1
//   ldX     : X <- x_in^2
//   initT1  : T <- 1.0 (priority over ldT)
//   initC1  : C <- 1.0 (priority over ldC)
//   ldT     : T <- scaled product
//   ldC     : C <- C + T (wraps; sets sticky ovf on signed overflow)
//   init0   : K <- 0, ovf <- 0 (priority over cntUp)
//   cntUp   : K <- K + 1 (wraps 7 -> 0)
//   selXR   : second multiplier operand: 1 = X, 0 = ROM R(K)
//   cnt8    : K == 7 (last iteration)
//   result  : accumulator C
//   ovf     : sticky accumulator overflow
// ---------------------------------------------------------------------------
module cos_dp #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         ldX,
    input  logic         initT1,
    input  logic         initC1,
    input  logic         ldT,
    input  logic         ldC,
    input  logic         init0,
    input  logic         cntUp,
    input  logic         selXR,
    output logic         cnt8,
    output logic [W-1:0] result,
    output logic         ovf
);

    localparam logic signed [W-1:0] ONE = W'(32'sd16384);

    logic signed [W-1:0]   x_r;
    logic signed [W-1:0]   t_r;
    logic signed [W-1:0]   c_r;
    logic        [2:0]     k_r;
    logic                  ovf_r;

    logic signed [W-1:0]   rom_r;
    logic signed [W-1:0]   mul_a;
    logic signed [W-1:0]   mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   prod_s;
    logic signed [W-1:0]   sum;
    logic                  sum_ovf;
    logic                  unused_prod;

    // Coefficients -1/((2k+1)(2k+2)), rounded to nearest Q2.14.
    always_comb begin
        rom_r = W'(-32'sd8192);
        case (k_r)
            3'd0: rom_r = W'(-32'sd8192);
            3'd1: rom_r = W'(-32'sd1365);
            3'd2: rom_r = W'(-32'sd546);
            3'd3: rom_r = W'(-32'sd293);
            3'd4: rom_r = W'(-32'sd182);
            3'd5: rom_r = W'(-32'sd124);
            3'd6: rom_r = W'(-32'sd90);
            3'd7: rom_r = W'(-32'sd68);
            default: rom_r = W'(-32'sd8192);
        endcase
    end

    // Single shared multiplier; ldX squares the incoming operand.
    always_comb begin
        mul_a = t_r;
        mul_b = selXR ? x_r : rom_r;
        if (ldX) begin
            mul_a = $signed(x_in);
            mul_b = $signed(x_in);
        end
    end

    assign prod = mul_a * mul_b;
    // Q4.28 -> Q2.14: drop 14 fraction bits (floor) and the top two bits
    // (plain wrap, no saturation).
    assign prod_s = prod[2*W-3:W-2];
    assign unused_prod = ^{prod[2*W-1:2*W-2], prod[W-3:0]};

    assign sum     = c_r + t_r;
    assign sum_ovf = (c_r[W-1] == t_r[W-1]) && (sum[W-1] != c_r[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= '0;
            t_r   <= '0;
            c_r   <= '0;
            k_r   <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (ldX)
                x_r <= prod_s;

            if (initT1)
                t_r <= ONE;
            else if (ldT)
                t_r <= prod_s;

            if (initC1)
                c_r <= ONE;
            else if (ldC)
                c_r <= sum;

            if (init0)
                k_r <= '0;
            else if (cntUp)
                k_r <= k_r + 3'd1;

            // init0 clears the sticky flag; otherwise an overflowing
            // accumulate sets it and nothing else touches it.
            if (init0)
                ovf_r <= 1'b0;
            else if (ldC && !initC1 && sum_ovf)
                ovf_r <= 1'b1;
        end
    end

    assign cnt8   = (k_r == 3'd7);
    assign result = c_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_cos_dp.sv
module tb_cos_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x_in;
    logic        ldX, initT1, initC1, ldT, ldC, init0, cntUp, selXR;
    logic        cnt8;
    logic [15:0] result;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    exp;
        int    tol;
    } exp_t;

    exp_t sb[$];

    int rom_exp [8] = '{-8192, -1365, -546, -293, -182, -124, -90, -68};

    always #5 clk = ~clk;

    cos_dp #(.W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_in  (x_in),
        .ldX   (ldX),
        .initT1(initT1),
        .initC1(initC1),
        .ldT   (ldT),
        .ldC   (ldC),
        .init0 (init0),
        .cntUp (cntUp),
        .selXR (selXR),
        .cnt8  (cnt8),
        .result(result),
        .ovf   (ovf)
    );

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic clr;
        ldX = 0; initT1 = 0; initC1 = 0; ldT = 0;
        ldC = 0; init0 = 0; cntUp = 0; selXR = 0;
    endtask

    // Inputs change at the falling edge; outputs are read there too.
    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int cos_ref(input int xv);
        real xr;
        xr = $itor(xv) / 16384.0;
        return int'($floor(16384.0 * $cos(xr) + 0.5));
    endfunction

    // Full controller sequence. abort_it >= 0 asserts rst between edges
    // in that iteration and abandons the run.
    task automatic run_seq(input string tag, input int xv, input int tol,
                           input bit chk_rom, input int abort_it);
        exp_t e;
        logic [7:0] mask;
        logic [15:0] xs;
        xs = 16'(xv);
        e.tag = tag;
        e.exp = (xv == 0) ? 16384 : cos_ref(xv);
        e.tol = tol;
        sb.push_back(e);

        x_in = xs;
        ldX = 1; initT1 = 1; initC1 = 1; init0 = 1;
        cyc();
        clr();
        chk_eq({tag, ".X"}, int'(dut.x_r), (xv * xv) / 16384);
        mask = '0;
        for (int it = 0; it < 8; it++) begin
            mask[it] = cnt8;
            selXR = 1; ldT = 1;
            cyc();
            if (it == abort_it) begin
                clr();
                #1 rst = 1;
                #1;
                chk_eq({tag, ".rst_result"}, int'(result), 0);
                chk_eq({tag, ".rst_cnt8"}, int'(cnt8), 0);
                chk_eq({tag, ".rst_ovf"}, int'(ovf), 0);
                rst = 0;
                void'(sb.pop_back());
                return;
            end
            selXR = 0; ldT = 1;
            if (chk_rom) chk_eq($sformatf("%s.rom%0d", tag, it), int'(dut.rom_r), rom_exp[it]);
            cyc();
            ldT = 0; ldC = 1; cntUp = 1;
            cyc();
            clr();
        end
        e = sb.pop_front();
        chk_tol({e.tag, ".result"}, int'($signed(result)), e.exp, e.tol);
        chk_eq({tag, ".ovf"}, int'(ovf), 0);
        chk_eq({tag, ".cnt8_mask"}, int'(mask), 8'h80);
        chk_eq({tag, ".cnt8_end"}, int'(cnt8), 0);
    endtask

    initial begin
        clr();
        x_in = '0;
        rst  = 1;
        #2;
        chk_eq("reset.result", int'(result), 0);
        chk_eq("reset.cnt8", int'(cnt8), 0);
        chk_eq("reset.ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 0;
        cyc();
        chk_eq("hold.result", int'(result), 0);

        // x = 0 gives exactly 1.0
        run_seq("x0", 0, 0, 1'b0, -1);
        // x = 1.0 -> 8852
        chk_eq("ref.x1", cos_ref(16384), 8852);
        run_seq("x1", 16384, 6, 1'b0, -1);
        // x = -0.5 -> 14378, ROM walked in order
        chk_eq("ref.xm05", cos_ref(-8192), 14378);
        run_seq("xm05", -8192, 6, 1'b1, -1);
        run_seq("xm1", -16384, 6, 1'b0, -1);
        run_seq("x073", 12000, 6, 1'b0, -1);

        // Accumulator wrap and sticky overflow
        initT1 = 1; initC1 = 1; init0 = 1;
        cyc(); clr();
        ldC = 1; cyc(); clr();
        chk_eq("ovf.wrap_c", int'($signed(result)), -32768);
        chk_eq("ovf.set", int'(ovf), 1);
        ldC = 1; cyc(); clr();
        chk_eq("ovf.c2", int'($signed(result)), -16384);
        chk_eq("ovf.sticky", int'(ovf), 1);
        init0 = 1; cyc(); clr();
        chk_eq("ovf.clear", int'(ovf), 0);

        // Counter wrap and init0 priority
        init0 = 1; cyc(); clr();
        for (int i = 1; i <= 8; i++) begin
            cntUp = 1; cyc(); clr();
            if (i == 7) chk_eq("cnt.after7", int'(cnt8), 1);
            if (i == 6) chk_eq("cnt.after6", int'(cnt8), 0);
        end
        chk_eq("cnt.after8_k", int'(dut.k_r), 0);
        chk_eq("cnt.after8", int'(cnt8), 0);
        cntUp = 1; cyc(); cyc(); cyc(); clr();
        chk_eq("cnt.k3", int'(dut.k_r), 3);
        cntUp = 1; init0 = 1; cyc(); clr();
        chk_eq("cnt.init0_prio", int'(dut.k_r), 0);

        // Reset mid-computation, then a fresh run
        run_seq("abort", 16384, 6, 1'b0, 4);
        cyc();
        chk_eq("abort.hold", int'(result), 0);
        run_seq("after_rst", 16384, 6, 1'b0, -1);

        chk_eq("sb.empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cos_dp.md
COS_DP -- requirements
Module: cos_dp

Interface
REQ-001 SHALL have parameter W, default 16: datapath word width, signed Q2.14 fixed point (14 fraction bits); only W=16 is required to be supported.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port x_in, input, W: signed operand x (Q2.14), sampled only when ldX=1.
REQ-005 SHALL have ports ldX, initT1, initC1, ldT, ldC, init0, cntUp, selXR, input, 1 each: control strobes from the cos controller, sampled each clk edge.
REQ-006 SHALL have port cnt8, output, 1: last-iteration flag back to the controller.
REQ-007 SHALL have port result, output, W: accumulator C (the cos(x) estimate), combinationally driven from C.
REQ-008 SHALL have port ovf, output, 1: sticky accumulator-overflow flag.

Function
REQ-009 SHALL hold registers X (W), T (W), C (W), iteration counter K (3 bits) and ovf (1 bit).
REQ-010 SHALL contain exactly one signed W x W multiplier; the 2W-bit product P is scaled as P[2W-3:W-2] (arithmetic shift right by 14, truncation toward minus infinity, upper bits discarded, no saturation).
REQ-011 SHALL select multiplier operands: ldX=1 -> (x_in, x_in); otherwise A=T and B=X when selXR=1, B=R when selXR=0.
REQ-012 SHALL load X with the scaled product on ldX=1, so X holds x^2.
REQ-013 SHALL provide an 8-entry coefficient ROM R indexed by K, R(k)=-1/((2k+1)(2k+2)) rounded to nearest Q2.14: K0..K7 = -8192, -1365, -546, -293, -182, -124, -90, -68.
REQ-014 SHALL load T with 16384 (1.0) on initT1=1; else with the scaled product on ldT=1; else hold. initT1 has priority over ldT.
REQ-015 SHALL load C with 16384 on initC1=1; else with the W-bit wrapped sum C+T on ldC=1; else hold. initC1 has priority over ldC.
REQ-016 SHALL set ovf when ldC=1 (and initC1=0) and C+T overflows in signed arithmetic (operands same sign, sum different sign); ovf stays set until init0=1 or reset.
REQ-017 SHALL clear K to 0 on init0=1; else increment K on cntUp=1, wrapping 7 -> 0; init0 has priority over cntUp.
REQ-018 SHALL drive cnt8=1 exactly when K==7 (combinational from K).
REQ-019 SHALL, under the controller sequence (load; then per iteration selXR+ldT, ldT, ldC+cntUp; 8 iterations), produce C = 1 - x^2/2! + ... + x^16/16!, ready on the edge of the final ldC.
REQ-020 SHALL guarantee |result - round(16384*cos(x))| <= 6 LSB for |x_in| <= 16384; outside that range behaviour is per REQ-010/015 wrap rules, not accuracy.
REQ-021 SHALL accept any combination of strobes in one cycle; unrelated registers update independently per their own rules.

Reset
REQ-022 SHALL on rst=1 immediately set X=0, T=0, C=0, K=0, ovf=0; hence result=0, cnt8=0, ovf=0.
REQ-023 SHALL treat rst asserted mid-computation identically; after release, registers hold until the next strobe.

Verification
REQ-024 SHALL be verified by: reset, x_in=0, full controller sequence -> result=16384, ovf=0, cnt8 high during 8th iteration only.
REQ-025 SHALL be verified by: x_in=16384 (1.0), full sequence -> result within 8852 +/-6, X=16384 after load.
REQ-026 SHALL be verified by: x_in=-8192 (-0.5), full sequence -> result within 14378 +/-6; ROM value observed at each MULT2 equals the REQ-013 list in order.
REQ-027 SHALL be verified by: initT1+initC1+init0 in one cycle, then one ldC -> C=-32768 (wrapped), ovf=1; a further ldC leaves ovf=1; then init0 -> ovf=0.
REQ-028 SHALL be verified by: eight cntUp pulses from K=0 -> cnt8 high after the 7th, K back to 0 and cnt8 low after the 8th; cntUp+init0 together -> K=0.
REQ-029 SHALL be verified by: rst asserted between clk edges during iteration 4 -> all outputs 0 before the next edge; a fresh sequence with x_in=16384 then gives 8852 +/-6.
